// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the TX weighted round-robin scheduler.
package tx_sched_pkg;

    localparam int NQ_DEF = 3;
    localparam int WW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        GRANT  = 2'd2
    } sched_state_e;

    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/tx_wrr_scheduler_rr_pick.sv
// Circular priority picker: first set mask bit strictly after ptr, wrapping around.
module rr_pick #(
    parameter int NQ = 3,
    parameter int PW = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic [NQ-1:0] mask,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int cand;

    // Scan outward from ptr+1 so the queue just served has lowest priority.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NQ) begin
                cand = cand - NQ;
            end
            if (!valid && mask[cand[PW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_wrr_scheduler.sv
// Weighted round-robin selector for the TX egress queues; holds one-hot gnt for a whole packet.
module tx_wrr_scheduler
    import tx_sched_pkg::*;
#(
    parameter int NQ = NQ_DEF,
    parameter int WW = WW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NQ-1:0]    req,
    input  logic             arb_nxt,
    input  logic [NQ*WW-1:0] weight,
    output logic [NQ-1:0]    gnt,
    output logic             busy,
    output logic             round_start
);

    localparam int PW = (NQ > 1) ? $clog2(NQ) : 1;

    sched_state_e  state;
    logic [WW-1:0] credit [NQ];
    logic [PW-1:0] ptr;
    logic [NQ-1:0] elig;
    logic [NQ-1:0] want;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;

    // A zero weight disables a queue outright, regardless of its leftover credit.
    always_comb begin
        want = '0;
        elig = '0;
        for (int i = 0; i < NQ; i++) begin
            want[i] = req[i] & (weight[i*WW +: WW] != '0);
            elig[i] = want[i] & (credit[i] != '0);
        end
    end

    rr_pick #(
        .NQ (NQ),
        .PW (PW)
    ) u_pick (
        .mask  (elig),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
            round_start <= 1'b0;
            ptr         <= PW'(NQ - 1);
            for (int i = 0; i < NQ; i++) begin
                credit[i] <= '0;
            end
        end else begin
            round_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt   <= NQ'(onehot(32'(pick_idx)));
                        ptr   <= pick_idx;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end else if (|want) begin
                        round_start <= 1'b1;
                        state       <= RELOAD;
                    end
                end
                RELOAD: begin
                    for (int i = 0; i < NQ; i++) begin
                        credit[i] <= weight[i*WW +: WW];
                    end
                    state <= IDLE;
                end
                GRANT: begin
                    // Grant is held even if req drops; only the packet end releases it.
                    if (arb_nxt) begin
                        if (credit[ptr] != '0) begin
                            credit[ptr] <= credit[ptr] - 1'b1;
                        end
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_wrr_scheduler.sv
// Directed scoreboard bench for tx_wrr_scheduler: expected grant order queued, checked per packet.
module tb_tx_wrr_scheduler;

    localparam int NQ = 3;
    localparam int WW = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NQ-1:0]    req = '0;
    logic             arb_nxt = 1'b0;
    logic [NQ*WW-1:0] weight = '0;
    logic [NQ-1:0]    gnt;
    logic             busy;
    logic             round_start;

    int checks = 0;
    int errors = 0;
    int rs_count = 0;
    int gnt_cycles [NQ] = '{default: 0};
    int rs_base;
    int q0_base;
    int q2_base;
    logic [NQ-1:0] exp_q [$];

    tx_wrr_scheduler #(
        .NQ (NQ),
        .WW (WW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .arb_nxt     (arb_nxt),
        .weight      (weight),
        .gnt         (gnt),
        .busy        (busy),
        .round_start (round_start)
    );

    always #5 clk = ~clk;

    // Free-running monitors; tests compare deltas against snapshots.
    always @(negedge clk) begin
        if (round_start === 1'b1) rs_count++;
        for (int i = 0; i < NQ; i++) begin
            if (gnt[i] === 1'b1) gnt_cycles[i]++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NQ-1:0] r, input logic [NQ*WW-1:0] w);
        req    = r;
        weight = w;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        arb_nxt = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        int n;
        logic [NQ-1:0] exp;
        n = 0;
        while (gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(gnt == '0), 32'd0);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checkOutput(tag, 32'(gnt), 32'(exp));
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic finish_packet(input int hold);
        logic [NQ-1:0] g;
        g = gnt;
        repeat (hold - 1) begin
            @(negedge clk);
            checkOutput("gnt_held", 32'(gnt), 32'(g));
        end
        @(posedge clk);
        #1 arb_nxt = 1'b1;
        @(posedge clk);
        #1 arb_nxt = 1'b0;
        @(negedge clk);
        checkOutput("gnt_gap", 32'(gnt), 32'd0);
        checkOutput("busy_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [NQ-1:0] order [6];

        // Reset and idle with no requests
        #2;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        apply_reset();
        rs_base = rs_count;
        repeat (20) @(negedge clk);
        checkOutput("idle_gnt", 32'(gnt), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_round_start", 32'(rs_count - rs_base), 32'd0);

        // Weights q2=3 q1=2 q0=1, all requesting: two full rounds
        apply_reset();
        rs_base = rs_count;
        order = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b100};
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) exp_q.push_back(order[k]);
        end
        applyStimulus(3'b111, 12'h321);
        for (int k = 0; k < 12; k++) begin
            wait_grant("wrr_grant");
            finish_packet(5);
        end
        req = '0;
        checkOutput("wrr_rounds", 32'(rs_count - rs_base), 32'd2);

        // Single requester q1 with weight 2
        apply_reset();
        rs_base = rs_count;
        q0_base = gnt_cycles[0];
        q2_base = gnt_cycles[2];
        for (int k = 0; k < 3; k++) exp_q.push_back(3'b010);
        applyStimulus(3'b010, 12'h121);
        for (int k = 0; k < 3; k++) begin
            wait_grant("single_grant");
            finish_packet(5);
        end
        req = '0;
        checkOutput("single_rounds", 32'(rs_count - rs_base), 32'd2);
        checkOutput("single_no_q0", 32'(gnt_cycles[0] - q0_base), 32'd0);
        checkOutput("single_no_q2", 32'(gnt_cycles[2] - q2_base), 32'd0);

        // q2 disabled by zero weight
        apply_reset();
        rs_base = rs_count;
        q2_base = gnt_cycles[2];
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(3'b001);
            exp_q.push_back(3'b010);
        end
        applyStimulus(3'b111, 12'h011);
        for (int k = 0; k < 6; k++) begin
            wait_grant("w0_grant");
            finish_packet(4);
        end
        req = '0;
        checkOutput("w0_rounds", 32'(rs_count - rs_base), 32'd3);
        checkOutput("w0_no_q2", 32'(gnt_cycles[2] - q2_base), 32'd0);

        // req[0] drops while q0 is granted
        apply_reset();
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        applyStimulus(3'b111, 12'h111);
        wait_grant("drop_grant");
        @(posedge clk);
        #1 req = 3'b110;
        finish_packet(5);
        wait_grant("drop_next");
        finish_packet(3);
        req = '0;

        // Async reset mid-packet
        apply_reset();
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        applyStimulus(3'b111, 12'h111);
        wait_grant("rst_first");
        finish_packet(3);
        wait_grant("rst_q1");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rs_base = rs_count;
        exp_q.delete();
        exp_q.push_back(3'b001);
        wait_grant("rst_after");
        checkOutput("rst_reload", 32'(rs_count - rs_base), 32'd1);
        finish_packet(3);
        req = '0;

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
